// File: rtl/wb_ctrl_pkg.sv
// Shared opcode map, sub-op codes and halt state type for the write-back controller.
package wb_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_ALU1 = 4'd6;
    localparam logic [3:0] OP_STK  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd10;
    localparam logic [3:0] OP_FLOW = 4'd11;
    localparam logic [3:0] OP_LDX  = 4'd12;
    localparam logic [3:0] OP_LDR  = 4'd13;
    localparam logic [3:0] OP_RSV  = 4'd14;
    localparam logic [3:0] OP_HLT  = 4'd15;

    // Sub-operations carried in the ra field of OP_STK and OP_FLOW
    localparam logic [1:0] SUB_PUSH = 2'd0;
    localparam logic [1:0] SUB_POP  = 2'd1;
    localparam logic [1:0] SUB_OUT  = 2'd2;
    localparam logic [1:0] SUB_IN   = 2'd3;
    localparam logic [1:0] SUB_CALL = 2'd1;
    localparam logic [1:0] SUB_RET  = 2'd2;
    localparam logic [1:0] SUB_RTI  = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/wb_halt_fsm.sv
// Halt sequencer: RUN -> DRAIN (DRAIN_CYC cycles) -> HALTED, left again by a resume pulse.
module wb_halt_fsm
    import wb_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic hlt_commit,
    input  logic resume,
    output logic halted
);

    localparam int CNT_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    halt_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The counter is loaded on entry so that DRAIN lasts exactly DRAIN_CYC cycles
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RUN: begin
                if (hlt_commit) begin
                    if (DRAIN_CYC == 0) begin
                        state_n = HALTED;
                    end else begin
                        state_n = DRAIN;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_n = HALTED;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HALTED: begin
                if (resume) begin
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    assign halted = (state == HALTED);

endmodule

// File: rtl/wb_ctrl_seq.sv
// Write-back controller: RF write decode, stack pointer, OUT port and halt sequencing.
// Optional feature macro: WB_OUT_HANDSHAKE_EN (OUT port held until out_ack).
module wb_ctrl_seq
    import wb_ctrl_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                REG_AW    = 2,
    parameter int                SP_IDX    = 3,
    parameter logic [DATA_W-1:0] SP_RESET  = 8'hFF,
    parameter int                DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [3:0]        opcode,
    input  logic [REG_AW-1:0] ra_wb,
    input  logic [REG_AW-1:0] rb_wb,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] in_port,
    input  logic              resume,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              stall_o,
    output logic              halted
);

    localparam logic [REG_AW-1:0] SP_ADDR = REG_AW'(SP_IDX);
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

    logic is_write, use_ra;
    logic is_stk, is_flow;
    logic is_push, is_pop, is_out, is_in, is_call, is_ret, is_hlt;
    logic commit, out_block, sp_load;

    always_comb begin
        is_write = 1'b0;
        use_ra   = 1'b0;
        case (opcode)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_LDI: begin
                is_write = 1'b1;
                use_ra   = 1'b1;
            end
            OP_ALU1, OP_LDX: is_write = (ra_wb < REG_AW'(2));
            OP_STK:          is_write = (ra_wb == REG_AW'(SUB_POP)) || (ra_wb == REG_AW'(SUB_IN));
            OP_LDR:          is_write = 1'b1;
            default:         is_write = 1'b0;
        endcase
    end

    assign is_stk  = (opcode == OP_STK);
    assign is_flow = (opcode == OP_FLOW);
    assign is_push = is_stk  && (ra_wb == REG_AW'(SUB_PUSH));
    assign is_pop  = is_stk  && (ra_wb == REG_AW'(SUB_POP));
    assign is_out  = is_stk  && (ra_wb == REG_AW'(SUB_OUT));
    assign is_in   = is_stk  && (ra_wb == REG_AW'(SUB_IN));
    assign is_call = is_flow && (ra_wb == REG_AW'(SUB_CALL));
    assign is_ret  = is_flow && ((ra_wb == REG_AW'(SUB_RET)) || (ra_wb == REG_AW'(SUB_RTI)));
    assign is_hlt  = (opcode == OP_HLT);

`ifdef WB_OUT_HANDSHAKE_EN
    // A new OUT must wait until the consumer has taken the previous value
    assign out_block = wb_valid & is_out & out_valid & ~out_ack;
`else
    logic unused_out_ack;
    assign unused_out_ack = out_ack;
    assign out_block      = 1'b0;
`endif

    assign stall_o  = halted | out_block;
    assign commit   = wb_valid & ~stall_o & ~halted;

    assign rf_we    = commit & is_write;
    assign rf_waddr = use_ra ? ra_wb : rb_wb;
    assign rf_wdata = is_in ? in_port : wb_data;
    assign sp_load  = rf_we & (rf_waddr == SP_ADDR);

    // An explicit write to the SP alias overrides the implicit push/pop adjustment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= SP_RESET;
        end else if (commit) begin
            if (sp_load) begin
                sp <= rf_wdata;
            end else if (is_push || is_call) begin
                sp <= sp - ONE;
            end else if (is_pop || is_ret) begin
                sp <= sp + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_port  <= '0;
            out_valid <= 1'b0;
        end else begin
`ifdef WB_OUT_HANDSHAKE_EN
            if (commit && is_out) begin
                out_port  <= wb_data;
                out_valid <= 1'b1;
            end else if (out_ack) begin
                out_valid <= 1'b0;
            end
`else
            out_valid <= commit & is_out;
            if (commit && is_out) begin
                out_port <= wb_data;
            end
`endif
        end
    end

    wb_halt_fsm #(
        .DRAIN_CYC (DRAIN_CYC)
    ) u_halt_fsm (
        .clk        (clk),
        .rst        (rst),
        .hlt_commit (commit & is_hlt),
        .resume     (resume),
        .halted     (halted)
    );

endmodule

// File: tb/tb_wb_ctrl_seq.sv
// Directed bench for wb_ctrl_seq: decode, SP arithmetic, OUT port, halt sequencing and reset.
module tb_wb_ctrl_seq;
    import wb_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid;
    logic [3:0] opcode;
    logic [1:0] ra_wb, rb_wb;
    logic [7:0] wb_data, in_port;
    logic       resume;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata, sp, out_port;
    logic       out_valid, out_ack, stall_o, halted;

    int n_compared = 0;
    int n_failed   = 0;

    wb_ctrl_seq dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .opcode    (opcode),
        .ra_wb     (ra_wb),
        .rb_wb     (rb_wb),
        .wb_data   (wb_data),
        .in_port   (in_port),
        .resume    (resume),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .sp        (sp),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .stall_o   (stall_o),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [1:0] ra,
                                 input logic [1:0] rb, input logic [7:0] data);
        wb_valid = v;
        opcode   = op;
        ra_wb    = ra;
        rb_wb    = rb;
        wb_data  = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_compared++;
        assert (observed === expected) else begin
            n_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; resume = 1'b0; out_ack = 1'b1; in_port = 8'h00;
        applyStimulus(0, OP_NOP, 0, 0, 8'h00);
        tick(); tick();
        checkOutput("rst_sp", 32'(sp), 'hFF);
        checkOutput("rst_out_port", 32'(out_port), 'h00);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_halted", 32'(halted), 0);
        checkOutput("rst_stall", 32'(stall_o), 0);
        rst = 1'b0;

        // PUSH x3, then reload SP to FE and POP x4 across the wrap
        applyStimulus(1, OP_STK, SUB_PUSH, 0, 8'h00);
        checkOutput("push_we", 32'(rf_we), 0);
        tick(); checkOutput("push1_sp", 32'(sp), 'hFE);
        tick(); checkOutput("push2_sp", 32'(sp), 'hFD);
        tick(); checkOutput("push3_sp", 32'(sp), 'hFC);
        applyStimulus(1, OP_MOV, 3, 0, 8'hFE);
        tick(); checkOutput("mov_sp_fe", 32'(sp), 'hFE);
        applyStimulus(1, OP_STK, SUB_POP, 0, 8'h99);
        checkOutput("pop_we", 32'(rf_we), 1);
        checkOutput("pop_waddr", 32'(rf_waddr), 0);
        tick(); checkOutput("pop1_sp", 32'(sp), 'hFF);
        tick(); checkOutput("pop2_sp", 32'(sp), 'h00);
        tick(); checkOutput("pop3_sp", 32'(sp), 'h01);
        tick(); checkOutput("pop4_sp", 32'(sp), 'h02);

        // Writes to the SP alias override the pop increment
        applyStimulus(1, OP_STK, SUB_POP, 3, 8'h40);
        checkOutput("popr3_waddr", 32'(rf_waddr), 3);
        tick(); checkOutput("popr3_sp", 32'(sp), 'h40);
        applyStimulus(1, OP_MOV, 3, 1, 8'h10);
        tick(); checkOutput("movr3_sp", 32'(sp), 'h10);
        applyStimulus(1, OP_FLOW, SUB_CALL, 0, 8'h00);
        checkOutput("call_we", 32'(rf_we), 0);
        tick(); checkOutput("call_sp", 32'(sp), 'h0F);
        applyStimulus(1, OP_FLOW, SUB_RET, 0, 8'h00);
        tick(); checkOutput("ret_sp", 32'(sp), 'h10);
        applyStimulus(1, OP_FLOW, SUB_RTI, 0, 8'h00);
        tick(); checkOutput("rti_sp", 32'(sp), 'h11);

        // Decode corners
        in_port = 8'hA5;
        applyStimulus(1, OP_STK, SUB_IN, 2, 8'h3C);
        checkOutput("in_we", 32'(rf_we), 1);
        checkOutput("in_waddr", 32'(rf_waddr), 2);
        checkOutput("in_wdata", 32'(rf_wdata), 'hA5);
        applyStimulus(1, OP_ALU1, 2, 1, 8'h00);
        checkOutput("setc_we", 32'(rf_we), 0);
        applyStimulus(1, OP_ALU1, 1, 2, 8'h00);
        checkOutput("op6_we", 32'(rf_we), 1);
        checkOutput("op6_waddr", 32'(rf_waddr), 2);
        applyStimulus(1, OP_ADD, 1, 2, 8'h5C);
        checkOutput("add_waddr", 32'(rf_waddr), 1);
        checkOutput("add_wdata", 32'(rf_wdata), 'h5C);
        applyStimulus(1, OP_ST, 1, 2, 8'h00);
        checkOutput("st_we", 32'(rf_we), 0);
        applyStimulus(1, OP_RSV, 0, 0, 8'h00);
        checkOutput("op14_we", 32'(rf_we), 0);
        for (int op = 0; op < 16; op++) begin
            applyStimulus(0, 4'(op), 1, 2, 8'h00);
            checkOutput($sformatf("bubble_we_op%0d", op), 32'(rf_we), 0);
        end
        checkOutput("bubble_sp", 32'(sp), 'h11);

        // OUT strobe
        applyStimulus(1, OP_STK, SUB_OUT, 1, 8'h5A);
        tick();
        checkOutput("out_port", 32'(out_port), 'h5A);
        checkOutput("out_valid_hi", 32'(out_valid), 1);
        applyStimulus(0, OP_NOP, 0, 0, 8'h00);
        tick();
        checkOutput("out_valid_lo", 32'(out_valid), 0);
        checkOutput("out_port_keep", 32'(out_port), 'h5A);

        // HLT, three drain cycles where the ADD behind it still writes, then halted
        applyStimulus(1, OP_HLT, 0, 0, 8'h00);
        tick();
        applyStimulus(1, OP_ADD, 1, 0, 8'h33);
        checkOutput("drain0_halted", 32'(halted), 0);
        checkOutput("drain0_we", 32'(rf_we), 1);
        tick(); checkOutput("drain1_halted", 32'(halted), 0);
        tick(); checkOutput("drain2_halted", 32'(halted), 0);
        checkOutput("drain2_we", 32'(rf_we), 1);
        tick();
        checkOutput("halt_halted", 32'(halted), 1);
        checkOutput("halt_stall", 32'(stall_o), 1);
        checkOutput("halt_we", 32'(rf_we), 0);
        applyStimulus(1, OP_STK, SUB_PUSH, 0, 8'h00);
        tick(); checkOutput("halt_push_sp", 32'(sp), 'h11);
        checkOutput("halt_hold", 32'(halted), 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        applyStimulus(0, OP_NOP, 0, 0, 8'h00);
        checkOutput("resume_halted", 32'(halted), 0);
        checkOutput("resume_stall", 32'(stall_o), 0);
        checkOutput("resume_sp", 32'(sp), 'h11);

        // Reset in the middle of DRAIN
        applyStimulus(1, OP_MOV, 3, 0, 8'h20);
        tick(); checkOutput("pre_rst_sp", 32'(sp), 'h20);
        applyStimulus(1, OP_HLT, 0, 0, 8'h00);
        tick();
        applyStimulus(1, OP_STK, SUB_OUT, 1, 8'h77);
        tick();
        checkOutput("drain_out_valid", 32'(out_valid), 1);
        applyStimulus(0, OP_NOP, 0, 0, 8'h00);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_sp", 32'(sp), 'hFF);
        checkOutput("mid_rst_halted", 32'(halted), 0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 0);
        checkOutput("mid_rst_out_port", 32'(out_port), 'h00);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        checkOutput("post_rst_halted", 32'(halted), 0);
        checkOutput("post_rst_stall", 32'(stall_o), 0);

`ifdef WB_OUT_HANDSHAKE_EN
        // Second OUT stalls until the consumer acknowledges the first
        out_ack = 1'b0;
        applyStimulus(1, OP_STK, SUB_OUT, 1, 8'h11);
        tick();
        checkOutput("hs_out1_port", 32'(out_port), 'h11);
        checkOutput("hs_out1_valid", 32'(out_valid), 1);
        applyStimulus(1, OP_STK, SUB_OUT, 2, 8'h22);
        checkOutput("hs_stall0", 32'(stall_o), 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("hs_hold_port%0d", i), 32'(out_port), 'h11);
            checkOutput($sformatf("hs_hold_stall%0d", i), 32'(stall_o), 1);
        end
        out_ack = 1'b1;
        #1;
        checkOutput("hs_ack_stall", 32'(stall_o), 0);
        tick();
        checkOutput("hs_out2_port", 32'(out_port), 'h22);
        checkOutput("hs_out2_valid", 32'(out_valid), 1);
        applyStimulus(0, OP_NOP, 0, 0, 8'h00);
        tick();
        checkOutput("hs_drop_valid", 32'(out_valid), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
